// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT16 constants and sequencer state type
package fft_pkg;
  localparam int FFT_N = 16;
  localparam int FFT_STAGES = $clog2(FFT_N);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fft_ctrl_state_e;
endpackage

// File: rtl/fft_valid_pipe.sv
// fft_valid_pipe: enable-gated valid shift register (clk, rst, clr, en, din -> vld[DEPTH])
module fft_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [DEPTH-1:0] vld
);
  always_ff @(posedge clk or posedge rst)
    if (rst) vld <= '0;
    else if (clr) vld <= '0;
    else if (en) vld <= (vld << 1) | DEPTH'(din);
endmodule

// File: rtl/fft16_seq_ctrl.sv
// fft16_seq_ctrl: FFT16 sequencer (frame handshakes, stage valids, enable, run/drain/abort FSM, frame counters)
module fft16_seq_ctrl
  import fft_pkg::*;
#(
  parameter int PIPE_LATENCY = FFT_STAGES,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_run,
  input  logic             flush,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fft_enable,
  output logic             busy,
  output logic [3:0]       occupancy,
  output logic [CNT_W-1:0] frames_in,
  output logic [CNT_W-1:0] frames_out,
  output logic [CNT_W-1:0] frames_drop
);
  fft_ctrl_state_e state;
  logic [PIPE_LATENCY-1:0] vld;
  logic adv, accept, deliver, any_vld;
  assign any_vld = |vld;
  assign out_valid = vld[PIPE_LATENCY-1];
  assign adv = !(out_valid && !out_ready);
  assign in_ready = adv && state == RUN && !abort;
  assign accept = in_valid && in_ready;
  assign deliver = out_valid && out_ready;
  assign fft_enable = adv && (any_vld || accept);
  assign busy = state != IDLE || any_vld;
  fft_valid_pipe #(.DEPTH(PIPE_LATENCY)) u_pipe (
    .clk(clk),
    .rst(rst),
    .clr(abort),
    .en (fft_enable),
    .din(accept),
    .vld(vld)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else if (abort) state <= IDLE;
    else
      case (state)
        IDLE:    if (cfg_run) state <= RUN;
        RUN:     if (flush || !cfg_run) state <= DRAIN;
        DRAIN:   if (!any_vld) state <= cfg_run ? RUN : IDLE;
        default: state <= IDLE;
      endcase
  // a frame delivered in the abort cycle leaves normally, so only the rest count as dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      occupancy   <= '0;
      frames_in   <= '0;
      frames_out  <= '0;
      frames_drop <= '0;
    end else begin
      occupancy   <= abort ? 4'd0 : occupancy + 4'(accept) - 4'(deliver);
      frames_in   <= frames_in + CNT_W'(accept);
      frames_out  <= frames_out + CNT_W'(deliver);
      frames_drop <= abort ? frames_drop + CNT_W'(occupancy - 4'(deliver)) : frames_drop;
    end
endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// tb_fft16_seq_ctrl: directed self-checking bench for fft16_seq_ctrl
module tb_fft16_seq_ctrl;
  logic clk = 0, rst = 1;
  logic cfg_run = 0, flush = 0, abort = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, fft_enable, busy;
  logic [3:0] occupancy, frames_in, frames_out, frames_drop;
  int n_chk = 0, n_pass = 0;
  int en_cnt, ov_cnt, occ_max, w;
  always #5 clk = ~clk;
  fft16_seq_ctrl #(.PIPE_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_run(cfg_run), .flush(flush), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .fft_enable(fft_enable), .busy(busy), .occupancy(occupancy),
    .frames_in(frames_in), .frames_out(frames_out), .frames_drop(frames_drop)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    {cfg_run, flush, abort, in_valid, out_ready} = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic start();
    cfg_run = 1;
    out_ready = 1;
    tick();
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_enable"}, fft_enable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_occ"}, occupancy, 0);
    check({tag, "_fin"}, frames_in, 0);
    check({tag, "_fout"}, frames_out, 0);
    check({tag, "_fdrop"}, frames_drop, 0);
  endtask
  initial begin
    #3;
    check_zero("rst");
    do_reset();
    // single frame: 4-cycle latency, one-cycle out_valid
    start();
    in_valid = 1;
    @(negedge clk);
    check("t1_ready", in_ready, 1);
    check("t1_enable", fft_enable, 1);
    tick();
    in_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("t1_ov%0d", i), out_valid, i == 4);
      tick();
    end
    check("t1_fin", frames_in, 1);
    check("t1_fout", frames_out, 1);
    cfg_run = 0;
    tick();
    tick();
    @(negedge clk);
    check("t1_busy", busy, 0);
    // 20 back-to-back frames
    do_reset();
    start();
    in_valid = 1;
    en_cnt = 0; ov_cnt = 0; occ_max = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 20) in_valid = 0;
      @(negedge clk);
      if (i < 20) en_cnt += int'(fft_enable);
      if (i >= 4) ov_cnt += int'(out_valid);
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      tick();
    end
    check("t2_enable_cnt", en_cnt, 20);
    check("t2_out_cnt", ov_cnt, 20);
    check("t2_occ_max", occ_max, 4);
    check("t2_fin", frames_in, 4);
    check("t2_fout", frames_out, 4);
    check("t2_occ_end", occupancy, 0);
    // full pipe stalled by out_ready=0 for 5 cycles
    do_reset();
    start();
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t3_en%0d", i), fft_enable, 0);
      check($sformatf("t3_rdy%0d", i), in_ready, 0);
      check($sformatf("t3_ov%0d", i), out_valid, 1);
      check($sformatf("t3_occ%0d", i), occupancy, 4);
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    ov_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ov_cnt += int'(out_valid);
      tick();
    end
    check("t3_out_cnt", ov_cnt, 4);
    check("t3_fin", frames_in, 4);
    check("t3_fout", frames_out, 4);
    // flush with 3 frames in flight
    do_reset();
    start();
    in_valid = 1;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 1;
    w = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        w = i;
        break;
      end
      tick();
    end
    check("t4_wait", w, 4);
    check("t4_fout", frames_out, 3);
    tick();
    in_valid = 0;
    check("t4_fin", frames_in, 4);
    // abort with 4 in flight while the head is delivered
    do_reset();
    start();
    in_valid = 1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 0;
    abort = 1;
    @(negedge clk);
    check("t5_ready", in_ready, 0);
    check("t5_ov", out_valid, 1);
    check("t5_occ", occupancy, 4);
    tick();
    abort = 0;
    @(negedge clk);
    check("t5_ov_after", out_valid, 0);
    check("t5_occ_after", occupancy, 0);
    check("t5_busy", busy, 0);
    check("t5_fdrop", frames_drop, 3);
    check("t5_fout", frames_out, 1);
    check("t5_fin", frames_in, 4);
    // counter wrap, then async reset mid-stall
    do_reset();
    start();
    in_valid = 1;
    for (int i = 0; i < 17; i++) tick();
    in_valid = 0;
    out_ready = 0;
    @(negedge clk);
    check("t6_fin_wrap", frames_in, 1);
    check("t6_stall_en", fft_enable, 0);
    check("t6_stall_ov", out_valid, 1);
    #2;
    rst = 1;
    #1;
    check_zero("t6_async");
    #10;
    rst = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
